eq_sweep_tester: RTL and testbench
==================================

// Module: eq_sweep_tester
// PURPOSE
//  Drives operand pairs into a W-bit equality comparator under test (eq2, or wider
//  compositions of eq1) and checks its aeqb result.
//  On start it sweeps all 2^(2W) (a,b) pairs and holds each pair for SETTLE cycles.
//  It then samples the comparator output, checks it against a==b, and keeps match and
//  error counters plus the index of the first failing pair.
//  Used on-board and in simulation as a self-checking harness for the comparator library.
// PARAMETERS
//  W       2  operand width driven to the comparator under test (DUT)
//  SETTLE  1  cycles each pair is held before sampling aeqb_in (>=1)
// PORTS
//  clk            in   1     system clock, rising edge
//  reset          in   1     asynchronous, active-high reset
//  start          in   1     request a sweep; accepted only in IDLE or DONE
//  a_out          out  W     operand a to DUT
//  b_out          out  W     operand b to DUT
//  aeqb_in        in   1     DUT equality result (combinational from a_out/b_out)
//  busy           out  1     high while a sweep is in progress
//  done           out  1     high in DONE state until next start or reset
//  match_cnt      out  2W+1  number of samples with aeqb_in==1
//  err_cnt        out  2W+1  number of samples with aeqb_in != (a_out==b_out)
//  first_err_idx  out  2W    pair index {a,b} of first error; valid when err_cnt!=0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; a_out, b_out, idx, counters and
//    first_err_idx = 0; busy=0, done=0.
//  - Pair index idx is 2W bits wide: a_out = idx[2W-1:W], b_out = idx[W-1:0].
//    Outputs are registered and change only on an idx update.
//  - FSM states: IDLE, HOLD, SAMPLE, DONE.
//    IDLE  : busy=0. On start, clear idx, counters and first_err_idx, load settle
//            count = SETTLE-1, and go to HOLD.
//    HOLD  : busy=1. Count down; at 0 go to SAMPLE. With SETTLE=1, HOLD lasts one cycle.
//    SAMPLE: busy=1. Evaluate exp = (a_out==b_out).
//            If aeqb_in, then match_cnt += 1.
//            If aeqb_in != exp, then err_cnt += 1; first_err_idx <= idx when err_cnt==0.
//            If idx == all-ones, go to DONE. Otherwise idx += 1, reload settle count,
//            and go to HOLD.
//    DONE  : busy=0, done=1. Counters hold. On start, behave as for start in IDLE.
//  - Latency: (SETTLE+1) cycles per pair. From the start-accept edge to done high is
//    2^(2W)*(SETTLE+1) cycles (W=2, SETTLE=1: 32).
//  - start is ignored in HOLD and SAMPLE; no restart mid-sweep. A start pulse of
//    any length is seen as one request, because the FSM leaves IDLE/DONE immediately.
//  - idx never wraps. The last pair ends in DONE, and idx keeps its all-ones value.
//  - Counters are sized 2W+1, so they cannot overflow (max 2^(2W)).
//  - Reset asserted mid-sweep aborts the sweep at once: all outputs go to reset
//    values, and no done is produced.
//  - aeqb_in is sampled only in SAMPLE. Glitches during HOLD are ignored.
// STRUCTURE
//  - Shared package: FSM state encoding (localparam ST_IDLE/ST_HOLD/ST_SAMPLE/ST_DONE)
//    and the width helper CNT_W = 2*W+1.
//  - One sub-module: sweep_settle_cnt, a loadable down-counter with a zero flag that
//    implements the HOLD timing.
//  - The rest is single-module: state register, idx register, and counter/error registers.
//  - The expected value (a_out==b_out) is computed behaviourally inside the tester,
//    never by instantiating eq1, so the DUT is checked independently.
// TESTING
//  1. W=2, SETTLE=1, correct eq2 attached, one-cycle start -> done at +32 cycles,
//     match_cnt=4, err_cnt=0, busy low.
//  2. Faulty DUT aeqb = e0^e1, one start -> match_cnt=8, err_cnt=12, first_err_idx=4'b0000.
//  3. DUT output stuck at 0 -> match_cnt=0, err_cnt=4, first_err_idx=0.
//     DUT stuck at 1 -> err_cnt=12, first_err_idx=4'b0001.
//  4. Assert start again at cycle 10 of a sweep -> ignored; done still at +32 and
//     counts unchanged. Then start in DONE -> counters cleared and a new 32-cycle sweep.
//  5. Assert reset asynchronously (off clock edge) at cycle 15 -> outputs 0 immediately,
//     state IDLE. After release, a new start gives a complete, correct sweep.
//  6. SETTLE=3 with a DUT model delaying aeqb by 2 cycles -> err_cnt=0, done at +64 cycles.
//     The same model with SETTLE=1 gives err_cnt>0.

Source files
------------

// File: rtl/eq_sweep_tester_pkg.sv
// rtl/eq_sweep_tester_pkg.sv - shared state encoding and width helper for the equality sweep tester
package eq_sweep_tester_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Counter width: 2^(2W) samples at most, so one extra bit keeps the count from wrapping
    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/eq_sweep_tester_settle_cnt.sv
// rtl/eq_sweep_tester_settle_cnt.sv - loadable down-counter with zero flag for the HOLD timing
module sweep_settle_cnt #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    // Load has priority; decrement saturates at zero so the flag stays up until reloaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/eq_sweep_tester.sv
// rtl/eq_sweep_tester.sv - exhaustive operand sweep and checker for a W-bit equality comparator
module eq_sweep_tester
    import eq_sweep_tester_pkg::*;
#(
    parameter int W      = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [W-1:0]       a_out,
    output logic [W-1:0]       b_out,
    input  logic               aeqb_in,
    output logic               busy,
    output logic               done,
    output logic [2*W:0]       match_cnt,
    output logic [2*W:0]       err_cnt,
    output logic [2*W-1:0]     first_err_idx
);

    localparam int CNT_W = cnt_w(W);
    localparam int IW    = 2 * W;
    localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_RELOAD = SW'(SETTLE - 1);

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic [CNT_W-1:0]    r_match;
    logic [CNT_W-1:0]    r_err;
    logic [IW-1:0]       r_first;
    logic                r_busy;
    logic                r_done;

    logic                w_exp;
    logic                w_last;
    logic                w_accept;
    logic                w_load;
    logic                w_dec;
    logic                w_zero;

    // Reference result is derived from the pair itself, independent of any comparator cell
    assign w_exp    = (r_idx[IW-1:W] == r_idx[W-1:0]);
    assign w_last   = &r_idx;
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_load   = w_accept || ((r_state == ST_SAMPLE) && !w_last);
    assign w_dec    = (r_state == ST_HOLD);

    sweep_settle_cnt #(
        .WIDTH (SW)
    ) u_settle (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_load_val (SETTLE_RELOAD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // Sweep FSM: step through every {a,b}, hold, sample aeqb_in, and accumulate results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_match <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_HOLD;
                        r_idx   <= '0;
                        r_match <= '0;
                        r_err   <= '0;
                        r_first <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (w_zero) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (aeqb_in) begin
                        r_match <= r_match + 1'b1;
                    end
                    if (aeqb_in != w_exp) begin
                        r_err <= r_err + 1'b1;
                        if (r_err == '0) begin
                            r_first <= r_idx;
                        end
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign a_out         = r_idx[IW-1:W];
    assign b_out         = r_idx[W-1:0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign match_cnt     = r_match;
    assign err_cnt       = r_err;
    assign first_err_idx = r_first;

endmodule

// File: tb/tb_eq_sweep_tester.sv
// tb/tb_eq_sweep_tester.sv - randomized self-checking bench with a behavioural sweep model
module tb_eq_sweep_tester;

    localparam int N = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int   mode = 0;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    logic [1:0] a_1, b_1, a_3, b_3;
    logic       aeqb_1, aeqb_3, busy_1, busy_3, done_1, done_3;
    logic [4:0] mc_1, ec_1, mc_3, ec_3;
    logic [3:0] fe_1, fe_3;
    logic [1:0] dly_1 = 2'b00;
    logic [1:0] dly_3 = 2'b00;
    logic [1:0][19:0] obs;

    // comparator personalities: 0 good, 1 xor-combined, 2 stuck0, 3 stuck1, 4 two-cycle delayed
    function automatic logic dut_out(input int m, input logic [1:0] a, input logic [1:0] b, input logic d);
        case (m)
            0: return a == b;
            1: return (a[0] == b[0]) ^ (a[1] == b[1]);
            2: return 1'b0;
            3: return 1'b1;
            default: return d;
        endcase
    endfunction

    always @(posedge clk) begin
        dly_1 <= {dly_1[0], a_1 == b_1};
        dly_3 <= {dly_3[0], a_3 == b_3};
    end

    assign aeqb_1 = dut_out(mode, a_1, b_1, dly_1[1]);
    assign aeqb_3 = dut_out(mode, a_3, b_3, dly_3[1]);
    assign obs = {{a_3, b_3, busy_3, done_3, mc_3, ec_3, fe_3},
                  {a_1, b_1, busy_1, done_1, mc_1, ec_1, fe_1}};

    eq_sweep_tester #(.W(2), .SETTLE(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start), .a_out(a_1), .b_out(b_1),
        .aeqb_in(aeqb_1), .busy(busy_1), .done(done_1), .match_cnt(mc_1),
        .err_cnt(ec_1), .first_err_idx(fe_1));

    eq_sweep_tester #(.W(2), .SETTLE(3)) u_s3 (
        .clk(clk), .reset(reset), .start(start), .a_out(a_3), .b_out(b_3),
        .aeqb_in(aeqb_3), .busy(busy_3), .done(done_3), .match_cnt(mc_3),
        .err_cnt(ec_3), .first_err_idx(fe_3));

    // behavioural model: per instance, edges elapsed since the accepted start (-1 = idle after reset)
    int s_of [2] = '{1, 3};
    int c    [2] = '{-1, -1};
    int pre  [2] = '{0, 0};
    int md   [2] = '{0, 0};

    function automatic bit eqp(input int p);
        return (p >> 2) == (p & 3);
    endfunction

    function automatic bit seen(input int m, input int s, input int p, input int pr);
        int a0, a1, b0, b1;
        a0 = (p >> 2) & 1; a1 = (p >> 3) & 1; b0 = p & 1; b1 = (p >> 1) & 1;
        case (m)
            0: return eqp(p);
            1: return (a0 == b0) ^ (a1 == b1);
            2: return 1'b0;
            3: return 1'b1;
            default: return (s >= 2) ? eqp(p) : eqp((p == 0) ? pr : p - 1);
        endcase
    endfunction

    function automatic logic [19:0] expect_out(input int k);
        int s, tot, comp, idx, m, e, f;
        bit bz, dn, sv;
        s = s_of[k]; tot = N * (s + 1); m = 0; e = 0; f = 0;
        if (c[k] < 0) return 20'd0;
        comp = (c[k] >= tot) ? N : c[k] / (s + 1);
        idx  = (comp > N - 1) ? N - 1 : comp;
        bz = (c[k] < tot);
        dn = !bz;
        for (int q = 0; q < comp; q++) begin
            sv = seen(md[k], s, q, pre[k]);
            if (sv) m++;
            if (sv != eqp(q)) begin
                if (e == 0) f = q;
                e++;
            end
        end
        return {2'(idx >> 2), 2'(idx & 3), bz, dn, 5'(m), 5'(e), 4'(f)};
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                c[k] <= -1;
            end else if (start && (c[k] < 0 || c[k] >= N * (s_of[k] + 1))) begin
                c[k]   <= 0;
                pre[k] <= (c[k] < 0) ? 0 : N - 1;
                md[k]  <= mode;
            end else if (c[k] >= 0 && c[k] < N * (s_of[k] + 1)) begin
                c[k] <= c[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== expect_out(k)) begin
                    bad++;
                    $display("FAIL cycle_check inst=%0d t=%0t got=%h want=%h", k, $time, obs[k], expect_out(k));
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // literal results for the two instances (SETTLE=1 / SETTLE=3) per comparator personality
    int lit_m1 [5] = '{4, 8, 0, 16, 4};
    int lit_e1 [5] = '{0, 12, 4, 12, 6};
    int lit_f1 [5] = '{0, 0, 0, 1, 1};
    int lit_m3 [5] = '{4, 8, 0, 16, 4};
    int lit_e3 [5] = '{0, 12, 4, 12, 0};
    int lit_f3 [5] = '{0, 0, 0, 1, 0};

    task automatic run_sweep(input int m, input int plen, input int mid_at);
        int t1, t3;
        t1 = -1; t3 = -1;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = (1 < plen) || (mid_at == 1);
        for (int cyc = 1; cyc <= 200 && (t1 < 0 || t3 < 0); cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (t1 < 0 && done_1) t1 = cyc;
            if (t3 < 0 && done_3) t3 = cyc;
            start = (cyc + 1 < plen) || (cyc + 1 == mid_at);
        end
        start = 1'b0;
        check($sformatf("done_latency_s1_mode%0d", m), t1, 32);
        check($sformatf("done_latency_s3_mode%0d", m), t3, 64);
        check($sformatf("match_s1_mode%0d", m), mc_1, lit_m1[m]);
        check($sformatf("err_s1_mode%0d", m), ec_1, lit_e1[m]);
        if (lit_e1[m] != 0) check($sformatf("first_s1_mode%0d", m), fe_1, lit_f1[m]);
        check($sformatf("match_s3_mode%0d", m), mc_3, lit_m3[m]);
        check($sformatf("err_s3_mode%0d", m), ec_3, lit_e3[m]);
        if (lit_e3[m] != 0) check($sformatf("first_s3_mode%0d", m), fe_3, lit_f3[m]);
        check($sformatf("busy_after_done_mode%0d", m), busy_1, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_state_s1", int'(obs[0]), 0);
        check("reset_state_s3", int'(obs[1]), 0);
        repeat (2) @(negedge clk);

        for (int m = 0; m < 5; m++) run_sweep(m, 1, 0);
        run_sweep(0, 2, 10);
        run_sweep(1, 1, 0);

        // abort mid-sweep with an off-edge reset, then sweep again
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_s1", int'(obs[0]), 0);
        check("async_reset_s3", int'(obs[1]), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_reset_done", done_1, 0);
        run_sweep(0, 1, 0);

        for (int r = 0; r < 5; r++) begin
            run_sweep(int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), int'($urandom_range(5, 20)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
